// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predict unit: branch condition codes, EX kinds and
// 2-bit saturating counter values.
package branch_predict_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    KindBranch = 2'b00,
    KindJal    = 2'b01,
    KindJalr   = 2'b10,
    KindNone   = 2'b11
  } ex_kind_e;

  localparam logic [1:0] CTR_RESET        = 2'b01;
  localparam logic [1:0] CTR_WEAK_TAKEN   = 2'b10;
  localparam logic [1:0] CTR_STRONG_TAKEN = 2'b11;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11) begin
      res = ctr + 2'd1;
    end else if (!taken && ctr != 2'b00) begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation from ALU flags; flags func3 codes that are
// not legal conditional branches.
module branch_cond_eval
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zf,
  input  logic       cf,
  input  logic       vf,
  input  logic       sf,
  output logic       taken,
  output logic       legal
);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (func3)
      BR_BEQ:  taken = zf;
      BR_BNE:  taken = ~zf;
      BR_BLT:  taken = sf ^ vf;
      BR_BGE:  taken = ~(sf ^ vf);
      // Unsigned compare: carry set means no borrow, i.e. a >= b.
      BR_BLTU: taken = ~cf;
      BR_BGEU: taken = cf;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with 2-bit counters for fetch prediction, EX
// resolution with misprediction/redirect, and saturating performance counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_inst_len,
  input  logic [XLEN-1:0] ex_target,
  input  logic            zf,
  input  logic            cf,
  input  logic            vf,
  input  logic            sf,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int unsigned Depth = 1 << IDX_BITS;
  localparam int unsigned TagLo = IDX_BITS + 1;
  localparam int unsigned TagHi = IDX_BITS + TAG_BITS;

  logic [Depth-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q    [Depth];
  logic [XLEN-1:0]     target_q [Depth];
  logic [1:0]          ctr_q    [Depth];

  // Predict
  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic                if_hit;

  assign if_idx = if_pc[IDX_BITS:1];
  assign if_tag = if_pc[TagHi:TagLo];
  assign if_hit = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag);

  assign pred_taken  = if_hit & ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : '0;

  logic unused_if_pc;
  assign unused_if_pc = ^{if_pc[XLEN-1:TagHi+1], if_pc[0]};

  // Resolve
  ex_kind_e kind;
  logic     cond_taken;
  logic     cond_legal;
  logic     is_branch;
  logic     is_jump;
  logic     active;

  assign kind = ex_kind_e'(ex_kind);

  branch_cond_eval u_cond (
    .func3 (ex_func3),
    .zf    (zf),
    .cf    (cf),
    .vf    (vf),
    .sf    (sf),
    .taken (cond_taken),
    .legal (cond_legal)
  );

  assign is_branch = (kind == KindBranch) & cond_legal;
  assign is_jump   = (kind == KindJal) | (kind == KindJalr);
  // Gated by rst so every output drops the moment reset is asserted.
  assign active    = rst & ex_valid & (is_branch | is_jump);

  logic [XLEN-1:0] fallthrough;
  assign fallthrough = ex_pc + (ex_inst_len ? XLEN'(4) : XLEN'(2));

  assign ex_taken    = active & (is_jump | cond_taken);
  assign mispredict  = active & ((ex_taken != ex_pred_taken) |
                                 (ex_taken & (ex_pred_target != ex_target)));
  assign redirect_pc = !rst ? '0 : (ex_taken ? ex_target : fallthrough);

  // Update
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic                upd_en;
  logic [1:0]          ctr_new;

  assign ex_idx = ex_pc[IDX_BITS:1];
  assign ex_tag = ex_pc[TagHi:TagLo];
  assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
  // A miss only allocates when taken; not-taken misses leave the table alone.
  assign upd_en = active & (ex_hit | ex_taken);

  always_comb begin
    ctr_new = CTR_STRONG_TAKEN;
    if (ex_hit) begin
      if (is_branch) begin
        ctr_new = ctr_step(ctr_q[ex_idx], ex_taken);
      end
    end else if (is_branch) begin
      ctr_new = CTR_WEAK_TAKEN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (upd_en) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_tag;
      ctr_q[ex_idx]   <= ctr_new;
      if (ex_taken) begin
        target_q[ex_idx] <= ex_target;
      end
    end
  end

  // Performance counters, saturating at all-ones
  logic [CNT_W-1:0] branches_q, branches_d;
  logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (active && branches_q != '1) begin
      branches_d = branches_q + CNT_W'(1);
    end
    if (mispredict && mispredicts_q != '1) begin
      mispredicts_d = mispredicts_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

endmodule
